// File: rtl/mult_pkg.sv
// Shared constants and FSM state encoding for the sequential multiplier controller.
package mult_pkg;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned RUN_CYCLES = 8;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StRun  = 3'd2,
    StCapt = 3'd3,
    StHold = 3'd4
  } state_e;

  // Width of a counter able to reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/op_fifo2.sv
// Two-entry operand-pair FIFO; full/empty come straight from the registered occupancy.
module op_fifo2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_a,
  input  logic [WIDTH-1:0] push_b,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_a,
  output logic [WIDTH-1:0] head_b
);

  logic [WIDTH-1:0] mem_a [2];
  logic [WIDTH-1:0] mem_b [2];
  logic             wr_q, rd_q;
  logic [1:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head_a  = mem_a[rd_q];
  assign head_b  = mem_b[rd_q];

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_ok) wr_q <= ~wr_q;
      if (pop_ok)  rd_q <= ~rd_q;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_a[wr_q] <= push_a;
      mem_b[wr_q] <= push_b;
    end
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Controller sequencing an external multi-cycle multiplier: buffers operand pairs,
// steps the multiplier for RUN_CYCLES cycles and holds each product until taken.
module seq_mult_ctrl #(
  parameter int unsigned WIDTH      = mult_pkg::WIDTH,
  parameter int unsigned RUN_CYCLES = mult_pkg::RUN_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mul_en,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  import mult_pkg::*;

  localparam int unsigned     CntW    = cnt_width(RUN_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(RUN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               out_valid_q;
  logic [2*WIDTH-1:0] out_p_q;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [WIDTH-1:0]   head_a, head_b;

  assign in_ready  = ~fifo_full;
  assign fifo_push = in_valid & ~fifo_full;

  op_fifo2 #(
    .WIDTH (WIDTH)
  ) u_op_fifo2 (
    .clk    (clk),
    .rst    (rst),
    .push   (fifo_push),
    .push_a (in_a),
    .push_b (in_b),
    .pop    (fifo_pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head_a (head_a),
    .head_b (head_b)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) state_d = StCapt;
      end
      StCapt: state_d = StHold;
      StHold: begin
        // Chain straight into the next operation when a pair is already waiting.
        if (out_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = StLoad;
          end else begin
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (fifo_pop) begin
        a_q <= head_a;
        b_q <= head_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
    end else if (state_q == StCapt) begin
      out_valid_q <= 1'b1;
      out_p_q     <= mul_c;
    end else if (state_q == StHold && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign mul_en    = (state_q == StRun) || (state_q == StCapt);
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: shift-add multiplier on the mul_* ports, scoreboard on the output.
module tb_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  in_a, in_b;
  logic        mul_en;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_c;
  logic        out_valid, out_ready;
  logic [15:0] out_p;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_p = '0, prev_p = '0;
  int          last_hs = 0, prev_hs = 0;
  int          n_out = 0;

  always #5 clk = ~clk;

  seq_mult_ctrl #(
    .WIDTH      (8),
    .RUN_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_en    (mul_en),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  // Behavioural shift-add multiplier: loads while mul_en is low, 8 steps while high.
  logic [15:0] m_acc, m_ash;
  logic [7:0]  m_bsh;
  int          m_cnt;
  always @(posedge clk) begin
    if (!mul_en) begin
      m_acc <= '0;
      m_ash <= {8'h00, mul_a};
      m_bsh <= mul_b;
      m_cnt <= 0;
    end else if (m_cnt < 8) begin
      if (m_bsh[0]) m_acc <= m_acc + m_ash;
      m_ash <= m_ash << 1;
      m_bsh <= m_bsh >> 1;
      m_cnt <= m_cnt + 1;
    end
  end
  assign mul_c = m_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard and hold-stability monitor; samples on the falling edge.
  initial begin : monitor
    bit          armed = 0;
    logic [15:0] held = '0;
    logic [15:0] prod;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        armed = 0;
      end else begin
        if (in_valid && in_ready) begin
          prod = {8'h00, in_a} * {8'h00, in_b};
          exp_q.push_back(prod);
        end
        if (armed && out_valid) check("hold_stable", out_p, held);
        if (out_valid && out_ready) begin
          check("q_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("product", out_p, exp_q.pop_front());
          prev_p  = last_p;
          last_p  = out_p;
          prev_hs = last_hs;
          last_hs = cyc;
          n_out++;
          armed = 0;
        end else if (out_valid) begin
          armed = 1;
          held  = out_p;
        end else begin
          armed = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bit done = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        n++;
        if (n >= 300) begin
          check("send_timeout", n, 0);
          done = 1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < max_cycles) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin : main
    int  lat, cnt, n, base;
    bit  seen, rdone;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_mul_en", mul_en, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);

    // Latency of a single pair into an idle controller.
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = 8'h0F;
    in_b     = 8'h0F;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 11);
    check("p_0f", out_p, 16'h00E1);
    check("hold_mul_en", mul_en, 0);
    out_ready = 1'b1;
    drain(100);

    // Ordering and throughput with out_ready held high.
    send(8'hFF, 8'hFF);
    send(8'h00, 8'hA5);
    drain(200);
    check("p_ff", prev_p, 16'hFE01);
    check("p_00", last_p, 16'h0000);
    check("throughput", last_hs - prev_hs, 11);

    // Back-to-back pairs with the consumer stalled.
    out_ready = 1'b0;
    base = n_out;
    send(8'h11, 8'h22);
    send(8'h33, 8'h44);
    send(8'h55, 8'h66);
    in_valid = 1'b1;
    in_a     = 8'h77;
    in_b     = 8'h88;
    @(negedge clk);
    check("full_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h77, 8'h88);
    drain(300);
    check("stall_count", n_out - base, 4);

    // Reset in the middle of RUN with a second pair buffered.
    send(8'h12, 8'h34);
    send(8'h55, 8'h66);
    cnt = 0;
    n   = 0;
    while (cnt < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (mul_en) cnt++;
    end
    check("run_reached", cnt, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("rst_no_valid", seen, 0);
    check("rst_in_ready2", in_ready, 1);
    @(posedge clk);
    #1;
    send(8'h12, 8'h34);
    drain(100);
    check("rst_redo", last_p, 16'h03A8);

    // Random pairs against random back-pressure.
    rdone = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
          end
          send(8'($urandom), 8'($urandom));
        end
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain(2000);
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width; product width is 2*WIDTH.
REQ-002 Parameter RUN_CYCLES, default 8: enabled multiplier cycles per operation; SHALL equal WIDTH.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair presented.
REQ-006 in_ready  output  1  operand buffer can accept a pair.
REQ-007 in_a  input  WIDTH  multiplicand.
REQ-008 in_b  input  WIDTH  multiplier.
REQ-009 mul_en  output  1  drives the multiplier's enable; low = load/clear, high = step.
REQ-010 mul_a  output  WIDTH  multiplicand to multiplier, held for the whole operation.
REQ-011 mul_b  output  WIDTH  multiplier operand, loaded by the multiplier while mul_en is low.
REQ-012 mul_c  input  2*WIDTH  product from multiplier.
REQ-013 out_valid  output  1  out_p holds a finished product.
REQ-014 out_ready  input  1  consumer takes out_p.
REQ-015 out_p  output  2*WIDTH  registered product.

Function
REQ-016 Transfer on each side SHALL occur only on a cycle where valid and ready are both high.
REQ-017 Operand pairs SHALL be buffered in a 2-entry FIFO; in_ready = FIFO not full, derived from registered occupancy only.
REQ-018 Push and pop in the same cycle SHALL leave occupancy unchanged; a push while full SHALL be impossible (in_ready low).
REQ-019 FSM states SHALL be IDLE, LOAD, RUN, CAPT, HOLD.
REQ-020 IDLE: if FIFO non-empty, pop head into a_reg/b_reg and go to LOAD; otherwise stay.
REQ-021 LOAD: one cycle, mul_en=0; go to RUN with run counter cleared.
REQ-022 RUN: mul_en=1; the 3-bit run counter increments every cycle; go to CAPT on the edge where the counter equals RUN_CYCLES-1 (exactly 8 RUN cycles).
REQ-023 CAPT: one cycle, mul_en=1; on its closing edge out_p <= mul_c, out_valid <= 1, go to HOLD.
REQ-024 HOLD: mul_en=0; out_valid=1 and out_p stable until out_ready.
REQ-025 HOLD exit on out_ready: if FIFO non-empty, pop and go to LOAD (out_valid drops); otherwise go to IDLE.
REQ-026 mul_en SHALL be high only in RUN and CAPT; mul_a = a_reg and mul_b = b_reg at all times.
REQ-027 Latency: a pair accepted at edge t into an empty FIFO with FSM in IDLE SHALL give out_valid high from edge t+11.
REQ-028 Throughput: with out_ready held high, one product SHALL complete every 11 cycles.
REQ-029 in_valid while FIFO not full SHALL be accepted in any FSM state, including HOLD with out_ready low.
REQ-030 Products SHALL be delivered in acceptance order, with no loss or duplication.

Reset
REQ-031 On rst: state=IDLE, FIFO empty, run counter=0, a_reg=b_reg=0, mul_en=0, out_valid=0, out_p=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-032 rst during any state, including RUN mid-count, SHALL abandon the operation and discard buffered pairs; no out_valid SHALL appear for them.
REQ-033 rst SHALL take priority over every simultaneous handshake.

Structure
REQ-034 Shared package mult_pkg SHALL hold WIDTH, RUN_CYCLES and the FSM state enum.
REQ-035 The 2-entry operand FIFO SHALL be a sub-module named op_fifo2; the FSM, run counter and output register stay in seq_mult_ctrl.

Verification
REQ-036 Single pair 0x0F x 0x0F accepted at edge t -> out_valid at t+11, out_p=0x00E1.
REQ-037 0xFF x 0xFF, then 0x00 x 0xA5 -> out_p 0xFE01, then 0x0000, in order.
REQ-038 Four back-to-back pairs with out_ready=0 -> first pair is popped, next two fill the FIFO, in_ready=0 on the fourth; all four products appear in order once out_ready=1.
REQ-039 out_ready toggled 0/1 while out_valid is high -> out_p is unchanged until the handshake, and exactly one transfer per product occurs.
REQ-040 rst pulsed at RUN cycle 4 of 0x12 x 0x34 -> no out_valid; a following 0x12 x 0x34 yields out_p=0x03A8.
REQ-041 A bench-side behavioural multiplier bound to the mul_* ports is checked against a reference model over 1000 random pairs with random out_ready -> all products match.
